// File: rtl/alu_pipe_n.sv
// alu_pipe_n: handshaked ALU, single-cycle logic/arith/shift ops plus a bit-serial shift-add multiplier
module alu_pipe_n #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             CI,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] FinalOut,
    output logic             CO,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf,
    output logic             Err,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state, stateNext;
    logic accept, isMul, lastStep;
    logic [SHW-1:0] amt;
    logic [WIDTH:0] addSum, subDiff, mulSum;
    logic [2*WIDTH-1:0] rolWide, prod, prodNext;
    logic [WIDTH-1:0] mcand, aluRes;
    logic [CW-1:0] cnt;
    logic aluCo, aluOvf;

    assign InReady  = !rst && (state == IDLE || (state == DONE && OutReady));
    assign accept   = InValid && InReady;
    assign isMul    = Op == 4'd10;
    assign lastStep = cnt == LAST;
    assign OutValid = state == DONE;
    assign Busy     = state == MUL;

    assign amt     = In2[SHW-1:0];
    assign addSum  = {1'b0, In1} + {1'b0, In2} + {{WIDTH{1'b0}}, CI};
    assign subDiff = {1'b0, In1} - {1'b0, In2};
    assign rolWide = {In1, In1} << amt;

    // Right-shifting product register: high half accumulates, low half holds the unconsumed multiplier bits
    assign mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prodNext = {mulSum, prod[WIDTH-1:1]};

    always_comb begin
        aluRes = '0;
        aluCo  = 1'b0;
        aluOvf = 1'b0;
        case (Op)
            4'd0: aluRes = In1 & In2;
            4'd1: aluRes = In1 | In2;
            4'd2: aluRes = In1 ^ In2;
            4'd3: aluRes = ~In1;
            4'd4: begin
                aluRes = addSum[WIDTH-1:0];
                aluCo  = addSum[WIDTH];
                aluOvf = In1[WIDTH-1] == In2[WIDTH-1] && addSum[WIDTH-1] != In1[WIDTH-1];
            end
            4'd5: aluRes = In1 << amt;
            4'd6: aluRes = In1 >> amt;
            4'd7: aluRes = $signed(In1) >>> amt;
            4'd8: begin
                aluRes = subDiff[WIDTH-1:0];
                aluCo  = !subDiff[WIDTH];
                aluOvf = In1[WIDTH-1] != In2[WIDTH-1] && subDiff[WIDTH-1] != In1[WIDTH-1];
            end
            4'd9: aluRes = rolWide[2*WIDTH-1:WIDTH];
            default: aluRes = '0;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: stateNext = accept ? (isMul ? MUL : DONE) : IDLE;
            MUL:  stateNext = lastStep ? DONE : MUL;
            DONE: stateNext = accept ? (isMul ? MUL : DONE) : (OutReady ? IDLE : DONE);
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            FinalOut <= '0;
            {CO, Zero, Neg, Ovf, Err} <= '0;
            prod  <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else if (accept && isMul) begin
            prod  <= {{WIDTH{1'b0}}, In2};
            mcand <= In1;
            cnt   <= '0;
        end else if (accept) begin
            FinalOut <= aluRes;
            CO   <= aluCo;
            Zero <= aluRes == '0;
            Neg  <= aluRes[WIDTH-1];
            Ovf  <= aluOvf;
            Err  <= Op > 4'd10;
        end else if (state == MUL) begin
            prod <= prodNext;
            cnt  <= cnt + 1'b1;
            if (lastStep) begin
                FinalOut <= prodNext[WIDTH-1:0];
                CO   <= |prodNext[2*WIDTH-1:WIDTH];
                Zero <= prodNext[WIDTH-1:0] == '0;
                Neg  <= prodNext[WIDTH-1];
                Ovf  <= 1'b0;
                Err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe_n.sv
// tb_alu_pipe_n: directed corner cases plus a randomized transaction-level regression against a reference model
module tb_alu_pipe_n;
    logic clk = 0, rst = 1, InValid = 0, InReady, CI = 0, OutValid, OutReady = 0;
    logic [3:0] Op = 0;
    logic [31:0] In1 = 0, In2 = 0, FinalOut;
    logic CO, Zero, Neg, Ovf, Err, Busy;
    int checks = 0, errors = 0;
    logic [36:0] q[$];

    alu_pipe_n #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady), .Op(Op), .In1(In1), .In2(In2),
        .CI(CI), .OutValid(OutValid), .OutReady(OutReady), .FinalOut(FinalOut), .CO(CO),
        .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .Err(Err), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic ci);
        InValid = 1; Op = op; In1 = a; In2 = b; CI = ci;
        tick();
        InValid = 0;
    endtask

    function automatic logic [4:0] flags();
        return {CO, Zero, Neg, Ovf, Err};
    endfunction

    // Result and flags from plain wide arithmetic; packed {res, CO, Zero, Neg, Ovf, Err}
    function automatic logic [36:0] refModel(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic ci);
        logic [31:0] r = '0;
        logic co = 0, ovf = 0, err = 0;
        longint x = $signed(a), y = $signed(b), s;
        logic [63:0] p;
        int n = int'(b[4:0]);
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = ~a;
            4: begin
                p = {32'b0, a} + {32'b0, b} + {63'b0, ci};
                r = p[31:0]; co = p[32];
                s = x + y + longint'(ci);
                ovf = s != longint'($signed(r));
            end
            5: r = a << n;
            6: r = a >> n;
            7: r = $signed(a) >>> n;
            8: begin
                r = a - b; co = a >= b;
                s = x - y;
                ovf = s != longint'($signed(r));
            end
            9: begin
                r = a;
                repeat (n) r = {r[30:0], r[31]};
            end
            10: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[31:0]; co = p[63:32] != 0;
            end
            default: err = 1;
        endcase
        return {r, co, r == 0, r[31], ovf, err};
    endfunction

    task automatic consume();
        if (OutValid && OutReady) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL rnd_spurious observed=result expected=none");
            end
            if (q.size() != 0) chk("rnd_result", {FinalOut, flags()}, q.pop_front());
        end
    endtask

    initial begin
        int n, busyCnt, accepted, cyc;
        logic [31:0] a, b;
        tick();
        #1;
        chk("rst_inready", InReady, 0);
        chk("rst_outs", {OutValid, Busy, FinalOut, flags()}, 0);
        rst = 0;
        #1;
        chk("post_rst_inready", InReady, 1);

        issue(4, 32'hFFFFFFFF, 32'h0, 1);
        chk("add_valid", OutValid, 1);
        chk("add_res", {FinalOut, flags()}, {32'h0, 5'b11000});
        OutReady = 1;
        tick();
        chk("add_consumed", OutValid, 0);

        issue(8, 32'h80000000, 32'h1, 0);
        chk("sub_res", {FinalOut, flags()}, {32'h7FFFFFFF, 5'b10010});
        tick();
        issue(7, 32'h80000000, 32'h1F, 0);
        chk("sra_res", {FinalOut, flags()}, {32'hFFFFFFFF, 5'b00100});
        tick();
        issue(9, 32'h80000001, 32'h20, 0);
        chk("rol0_res", {FinalOut, flags()}, {32'h80000001, 5'b00100});
        tick();
        issue(12, 32'h12345678, 32'h9ABCDEF0, 1);
        chk("illegal_res", {OutValid, FinalOut, flags()}, {1'b1, 32'h0, 5'b01001});
        tick();

        OutReady = 0;
        issue(10, 32'h00010000, 32'h00010001, 0);
        InValid = 1; Op = 0;
        #1;
        chk("mul_inready", InReady, 0);
        n = 0; busyCnt = 0;
        while (!OutValid && n < 40) begin
            busyCnt += int'(Busy);
            tick();
            n++;
        end
        chk("mul_latency", n, 32);
        chk("mul_busy_cycles", busyCnt, 32);
        chk("mul_busy_done", Busy, 0);
        chk("mul_res", {FinalOut, flags()}, {32'h00010000, 5'b10000});
        InValid = 0; OutReady = 1;
        tick();
        chk("mul_consumed", OutValid, 0);

        for (int i = 0; i < 8; i++) begin
            a = 32'h11111111 * (i + 1); b = 32'hA5A5A5A5 + i;
            issue(2, a, b, 0);
            chk("xor_stream_valid", OutValid, 1);
            chk("xor_stream_res", FinalOut, a ^ b);
        end
        OutReady = 0; InValid = 1; Op = 1; In1 = 32'hF0F0F0F0; In2 = 32'h0F0F0F0F;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_inready", InReady, 0);
            chk("hold_res", {OutValid, FinalOut}, {1'b1, a ^ b});
            tick();
        end
        InValid = 0; OutReady = 1;
        tick();

        issue(10, 32'hDEADBEEF, 32'h12345678, 0);
        repeat (9) tick();
        chk("abort_busy", Busy, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("abort_outs", {OutValid, Busy, FinalOut, flags()}, 0);
        chk("abort_inready", InReady, 1);
        n = 0;
        repeat (40) begin
            n += int'(OutValid);
            tick();
        end
        chk("abort_no_result", n, 0);

        accepted = 0; cyc = 0;
        while (accepted < 1000 && cyc < 40000) begin
            InValid = $urandom_range(0, 3) != 0;
            Op = 4'($urandom_range(0, 15));
            In1 = $urandom; In2 = $urandom; CI = 1'($urandom_range(0, 1));
            OutReady = $urandom_range(0, 3) != 0;
            #1;
            consume();
            if (InValid && InReady) begin
                q.push_back(refModel(Op, In1, In2, CI));
                accepted++;
            end
            tick();
            cyc++;
        end
        chk("rnd_accepted", accepted, 1000);
        InValid = 0; OutReady = 1;
        repeat (40) begin
            #1;
            consume();
            tick();
        end
        chk("rnd_leftover", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
